// File: rtl/uart_arbiter.sv
// Two-master round-robin arbiter in front of the uart register slave, one-deep pending slot per master.
// Latency: request pulse T -> response DV at T+4 uncontended; timeout response at T+3+TIMEOUT.
// Backpressure: busy is high while a port's slot is full; pulses arriving while busy are dropped.
module uart_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_m0_request,
    input  logic       i_m0_write,
    input  logic [2:0] i_m0_address,
    input  logic [7:0] i_m0_data,
    input  logic       i_m1_request,
    input  logic       i_m1_write,
    input  logic [2:0] i_m1_address,
    input  logic [7:0] i_m1_data,
    output logic [7:0] o_m0_data,
    output logic       o_m0_data_DV,
    output logic       o_m0_error,
    output logic       o_m0_busy,
    output logic [7:0] o_m1_data,
    output logic       o_m1_data_DV,
    output logic       o_m1_error,
    output logic       o_m1_busy,
    output logic       o_uart_request,
    output logic       o_uart_write,
    output logic [2:0] o_uart_address,
    output logic [7:0] o_uart_data,
    input  logic [7:0] i_uart_data,
    input  logic       i_uart_data_DV
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       pend0, pend1;
    logic       wr0, wr1;
    logic [2:0] addr0, addr1;
    logic [7:0] dat0, dat1;
    logic       grant, grant_nxt;
    logic       favor, favor_nxt;
    logic [7:0] count, count_nxt;
    logic [7:0] resp_dat, resp_dat_nxt;
    logic       resp_err, resp_err_nxt;
    logic       load;
    logic       enter_resp;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        favor_nxt    = favor;
        count_nxt    = count;
        resp_dat_nxt = resp_dat;
        resp_err_nxt = resp_err;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    // Contention is settled by favor; a lone requester wins outright.
                    grant_nxt = (pend0 && pend1) ? favor : pend1;
                    favor_nxt = ~grant_nxt;
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                count_nxt = 8'd0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (i_uart_data_DV) begin
                    resp_dat_nxt = i_uart_data;
                    resp_err_nxt = 1'b0;
                    state_nxt    = RESP;
                end else if (count == CNT_LAST) begin
                    resp_dat_nxt = 8'h00;
                    resp_err_nxt = 1'b1;
                    state_nxt    = RESP;
                end else begin
                    count_nxt = count + 8'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state == WAIT) && (state_nxt == RESP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            pend0          <= 1'b0;
            pend1          <= 1'b0;
            wr0            <= 1'b0;
            wr1            <= 1'b0;
            addr0          <= 3'd0;
            addr1          <= 3'd0;
            dat0           <= 8'd0;
            dat1           <= 8'd0;
            grant          <= 1'b0;
            favor          <= 1'b0;
            count          <= 8'd0;
            resp_dat       <= 8'd0;
            resp_err       <= 1'b0;
            o_uart_write   <= 1'b0;
            o_uart_address <= 3'd0;
            o_uart_data    <= 8'd0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            favor    <= favor_nxt;
            count    <= count_nxt;
            resp_dat <= resp_dat_nxt;
            resp_err <= resp_err_nxt;
            if (load) begin
                o_uart_write   <= grant_nxt ? wr1 : wr0;
                o_uart_address <= grant_nxt ? addr1 : addr0;
                o_uart_data    <= grant_nxt ? dat1 : dat0;
            end
            // A slot only accepts when empty and only clears when full, so set and clear never collide.
            if (i_m0_request && !pend0) begin
                pend0 <= 1'b1;
                wr0   <= i_m0_write;
                addr0 <= i_m0_address;
                dat0  <= i_m0_data;
            end else if (enter_resp && !grant) begin
                pend0 <= 1'b0;
            end
            if (i_m1_request && !pend1) begin
                pend1 <= 1'b1;
                wr1   <= i_m1_write;
                addr1 <= i_m1_address;
                dat1  <= i_m1_data;
            end else if (enter_resp && grant) begin
                pend1 <= 1'b0;
            end
        end
    end

    assign o_uart_request = (state == ISSUE);
    assign o_m0_data_DV   = (state == RESP) && !grant;
    assign o_m1_data_DV   = (state == RESP) && grant;
    assign o_m0_error     = o_m0_data_DV && resp_err;
    assign o_m1_error     = o_m1_data_DV && resp_err;
    assign o_m0_data      = o_m0_data_DV ? resp_dat : 8'h00;
    assign o_m1_data      = o_m1_data_DV ? resp_dat : 8'h00;
    assign o_m0_busy      = pend0;
    assign o_m1_busy      = pend1;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter with a small uart slave model (reg 5 reads 8'h20, others are RAM).
module tb_uart_arbiter;

    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_m0_request, i_m0_write, i_m1_request, i_m1_write;
    logic [2:0] i_m0_address, i_m1_address;
    logic [7:0] i_m0_data, i_m1_data;
    logic [7:0] o_m0_data, o_m1_data;
    logic       o_m0_data_DV, o_m0_error, o_m0_busy;
    logic       o_m1_data_DV, o_m1_error, o_m1_busy;
    logic       o_uart_request, o_uart_write;
    logic [2:0] o_uart_address;
    logic [7:0] o_uart_data;
    logic [7:0] uart_rd;
    logic       uart_dv;

    logic [7:0] mem [8] = '{default: 8'h00};
    logic       dv_q = 1'b0;
    logic       dv_en = 1'b1;
    logic       stray = 1'b0;
    logic [34:0] outs;

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    int dv0_cnt = 0;
    int dv1_cnt = 0;

    always #5 clk = ~clk;

    uart_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_m0_request(i_m0_request), .i_m0_write(i_m0_write),
        .i_m0_address(i_m0_address), .i_m0_data(i_m0_data),
        .i_m1_request(i_m1_request), .i_m1_write(i_m1_write),
        .i_m1_address(i_m1_address), .i_m1_data(i_m1_data),
        .o_m0_data(o_m0_data), .o_m0_data_DV(o_m0_data_DV),
        .o_m0_error(o_m0_error), .o_m0_busy(o_m0_busy),
        .o_m1_data(o_m1_data), .o_m1_data_DV(o_m1_data_DV),
        .o_m1_error(o_m1_error), .o_m1_busy(o_m1_busy),
        .o_uart_request(o_uart_request), .o_uart_write(o_uart_write),
        .o_uart_address(o_uart_address), .o_uart_data(o_uart_data),
        .i_uart_data(uart_rd), .i_uart_data_DV(uart_dv)
    );

    // Slave: DV one cycle after a sampled request; stray lets the bench inject an unsolicited DV.
    assign uart_rd = (o_uart_address == 3'd5) ? 8'h20 : mem[o_uart_address];
    assign uart_dv = dv_q | stray;
    assign outs = {o_m0_data, o_m0_data_DV, o_m0_error, o_m0_busy,
                   o_m1_data, o_m1_data_DV, o_m1_error, o_m1_busy,
                   o_uart_request, o_uart_write, o_uart_address, o_uart_data};

    always @(posedge clk) begin
        dv_q <= o_uart_request & dv_en;
        if (o_uart_request && o_uart_write) mem[o_uart_address] <= o_uart_data;
    end

    always @(negedge clk) begin
        if (o_uart_request) req_cnt <= req_cnt + 1;
        if (o_m0_data_DV) dv0_cnt <= dv0_cnt + 1;
        if (o_m1_data_DV) dv1_cnt <= dv1_cnt + 1;
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Holds the given request pulses for exactly one cycle; returns #1 into the following cycle.
    task automatic drive(input logic r0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
        i_m0_request = r0; i_m0_write = w0; i_m0_address = a0; i_m0_data = d0;
        i_m1_request = r1; i_m1_write = w1; i_m1_address = a1; i_m1_data = d1;
        cyc();
        i_m0_request = 1'b0;
        i_m1_request = 1'b0;
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        cyc();
        cyc();
        i_reset = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_m0_request = 1'b1;
        cyc();
        cyc();
        i_m0_request = 1'b0;
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 35'd0) begin
            failures++; $display("FAIL reset_outs got=%h exp=0", outs);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (o_m0_busy !== 1'b0 || o_uart_request !== 1'b0) begin
                failures++; $display("FAIL reset_req_ignored k=%0d busy=%b req=%b exp=0", k, o_m0_busy, o_uart_request);
            end
        end
        cyc();
    endtask

    task automatic test_single_read;
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (o_uart_request !== (k == 2)) begin
                failures++; $display("FAIL rd_uart_req k=%0d got=%b exp=%b", k, o_uart_request, k == 2);
            end
            checks++;
            if (o_m0_busy !== (k >= 1 && k <= 3)) begin
                failures++; $display("FAIL rd_busy0 k=%0d got=%b exp=%b", k, o_m0_busy, (k >= 1 && k <= 3));
            end
            checks++;
            if (o_m0_data_DV !== (k == 4) || o_m0_error !== 1'b0) begin
                failures++; $display("FAIL rd_dv0 k=%0d got=%b/%b exp=%b/0", k, o_m0_data_DV, o_m0_error, k == 4);
            end
            checks++;
            if (o_m0_data !== ((k == 4) ? 8'h20 : 8'h00)) begin
                failures++; $display("FAIL rd_data0 k=%0d got=%h exp=%h", k, o_m0_data, (k == 4) ? 8'h20 : 8'h00);
            end
            checks++;
            if ({o_m1_data, o_m1_data_DV, o_m1_error, o_m1_busy} !== 11'd0) begin
                failures++; $display("FAIL rd_m1_quiet k=%0d got=%h exp=0", k, {o_m1_data, o_m1_data_DV, o_m1_error, o_m1_busy});
            end
            if (k == 2) begin
                checks++;
                if (o_uart_address !== 3'd5 || o_uart_write !== 1'b0) begin
                    failures++; $display("FAIL rd_fields got=%0d/%b exp=5/0", o_uart_address, o_uart_write);
                end
            end
        end
        cyc();
    endtask

    task automatic test_write_read;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd1, 8'hA5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_m1_data_DV !== (k == 4)) begin
                failures++; $display("FAIL wr_dv1 k=%0d got=%b exp=%b", k, o_m1_data_DV, k == 4);
            end
            if (k == 2) begin
                checks++;
                if (o_uart_write !== 1'b1 || o_uart_address !== 3'd1 || o_uart_data !== 8'hA5) begin
                    failures++; $display("FAIL wr_fields got=%b/%0d/%h exp=1/1/a5", o_uart_write, o_uart_address, o_uart_data);
                end
            end
        end
        cyc();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_m1_data_DV !== (k == 4) || o_m1_data !== ((k == 4) ? 8'hA5 : 8'h00)) begin
                failures++; $display("FAIL wr_readback k=%0d got=%b/%h exp=%b/%h", k, o_m1_data_DV, o_m1_data, k == 4, (k == 4) ? 8'hA5 : 8'h00);
            end
        end
        cyc();
    endtask

    task automatic test_round_robin;
        do_reset();
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (o_m0_data_DV !== (k == 4) || o_m1_data_DV !== (k == 8)) begin
                failures++; $display("FAIL rr1_dv k=%0d got=%b%b exp=%b%b", k, o_m0_data_DV, o_m1_data_DV, k == 4, k == 8);
            end
            checks++;
            if (o_uart_request !== (k == 2 || k == 6)) begin
                failures++; $display("FAIL rr1_req k=%0d got=%b exp=%b", k, o_uart_request, (k == 2 || k == 6));
            end
            if (k == 4 || k == 8) begin
                checks++;
                if ((k == 4 && o_m0_data !== 8'h20) || (k == 8 && o_m1_data !== 8'hA5)) begin
                    failures++; $display("FAIL rr1_data k=%0d got=%h/%h exp=20/a5", k, o_m0_data, o_m1_data);
                end
            end
        end
        cyc();
        // A lone m0 grant hands favor to m1 for the next contention.
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (4) cyc();
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (o_m1_data_DV !== (k == 4) || o_m0_data_DV !== (k == 8)) begin
                failures++; $display("FAIL rr2_dv k=%0d got m0=%b m1=%b exp m0=%b m1=%b", k, o_m0_data_DV, o_m1_data_DV, k == 8, k == 4);
            end
        end
        cyc();
    endtask

    task automatic test_busy_drop;
        int b_req, b_dv;
        b_req = req_cnt;
        b_dv = dv0_cnt;
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc();
        drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_m0_data_DV !== 1'b1 || o_m0_data !== 8'h20) begin
            failures++; $display("FAIL drop_dv_t4 got=%b/%h exp=1/20", o_m0_data_DV, o_m0_data);
        end
        repeat (8) cyc();
        checks++;
        if (req_cnt - b_req !== 1 || dv0_cnt - b_dv !== 1) begin
            failures++; $display("FAIL drop_counts req=%0d dv=%0d exp=1/1", req_cnt - b_req, dv0_cnt - b_dv);
        end
    endtask

    task automatic test_timeout;
        int b_dv;
        dv_en = 1'b0;
        b_dv = dv1_cnt;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (o_m1_data_DV !== (k == 6) || o_m1_error !== (k == 6) || o_m1_data !== 8'h00) begin
                failures++; $display("FAIL tmo_resp k=%0d got=%b/%b/%h exp=%b/%b/00", k, o_m1_data_DV, o_m1_error, o_m1_data, k == 6, k == 6);
            end
            checks++;
            if (o_m1_busy !== (k <= 5)) begin
                failures++; $display("FAIL tmo_busy k=%0d got=%b exp=%b", k, o_m1_busy, k <= 5);
            end
            if (k == 7) stray = 1'b1;
            if (k == 8) stray = 1'b0;
        end
        cyc();
        checks++;
        if (dv1_cnt - b_dv !== 1 || o_uart_request !== 1'b0) begin
            failures++; $display("FAIL tmo_stray dv=%0d req=%b exp=1/0", dv1_cnt - b_dv, o_uart_request);
        end
        dv_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        int b_dv;
        dv_en = 1'b0;
        b_dv = dv0_cnt;
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) cyc();
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 35'd0) begin
            failures++; $display("FAIL midwait_outs got=%h exp=0", outs);
        end
        dv_en = 1'b1;
        repeat (6) cyc();
        checks++;
        if (dv0_cnt - b_dv !== 0) begin
            failures++; $display("FAIL midwait_no_dv got=%0d exp=0", dv0_cnt - b_dv);
        end
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_m0_data_DV !== (k == 4) || o_m0_data !== ((k == 4) ? 8'h20 : 8'h00)) begin
                failures++; $display("FAIL midwait_after k=%0d got=%b/%h exp=%b", k, o_m0_data_DV, o_m0_data, k == 4);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) cyc();
        drive(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int k = 5; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (o_uart_request !== (k == 6) || o_m0_data_DV !== (k == 8)) begin
                failures++; $display("FAIL b2b k=%0d got req=%b dv=%b exp req=%b dv=%b", k, o_uart_request, o_m0_data_DV, k == 6, k == 8);
            end
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b0;
        i_m0_request = 1'b0; i_m0_write = 1'b0; i_m0_address = 3'd0; i_m0_data = 8'h00;
        i_m1_request = 1'b0; i_m1_write = 1'b0; i_m1_address = 3'd0; i_m1_data = 8'h00;
        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_busy_drop();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
